// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS main controller.
//   - state_t        : FSM state encodings (also exported on the debug port)
//   - OP_*           : instruction opcodes (IR[31:26]) understood by the FSM
//   - ALUOP_*        : aluop encodings (aluctr convention)
//   - SRCB_*         : aluSrcB mux selects
//   - PCSRC_*        : pcSource mux selects
//   - CAUSE_*        : trapCause codes
//   - is_mem_state() : true for states that own a memory request
package mc_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that hold memReq high and wait for memAck.
  function automatic logic is_mem_state(input state_t s);
    logic r;
    case (s)
      ST_FETCH, ST_MEMRD, ST_MEMWR: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: control bundle between mc_ctrl and the datapath / memory.
//   master (controller): inputs opCode, memAck; drives every control,
//                        status and debug output.
//   slave  (datapath)  : the mirror image.
// Parameter CNT_W sizes instCount.
interface mc_if #(parameter int CNT_W = 32) ();

  logic [5:0]       opCode;
  logic             memAck;
  logic             memReq;
  logic             memRead;
  logic             memWrite;
  logic             iorD;
  logic             irWrite;
  logic             pcWrite;
  logic             pcWriteCond;
  logic [1:0]       pcSource;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluop;
  logic             regDst;
  logic             memToReg;
  logic             regWrite;
  logic             trap;
  logic [1:0]       trapCause;
  logic [3:0]       state;
  logic [CNT_W-1:0] instCount;

  modport master (
    input  opCode, memAck,
    output memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
           pcSource, aluSrcA, aluSrcB, aluop, regDst, memToReg, regWrite,
           trap, trapCause, state, instCount
  );

  modport slave (
    output opCode, memAck,
    input  memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
           pcSource, aluSrcA, aluSrcB, aluop, regDst, memToReg, regWrite,
           trap, trapCause, state, instCount
  );

endinterface

// File: rtl/mc_memwait.sv
// mc_memwait: bounded wait on the memory acknowledge.
//   clkin, reset : clock, asynchronous active-low reset
//   inMemState   : FSM currently sits in a memory state
//   memAck       : memory acknowledge this cycle
//   stateEntry   : FSM enters a memory state on the next edge
//   timeout      : this is the last allowed cycle and memAck is still low
// ACK_TIMEOUT = 0 disables the timeout.
module mc_memwait #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clkin,
  input  logic reset,
  input  logic inMemState,
  input  logic memAck,
  input  logic stateEntry,
  output logic timeout
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // Counter value on the final permitted wait cycle.
  localparam logic [CW-1:0] LIMIT = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : CNT_MAX;

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  // Next count: restart on entry, otherwise count unacknowledged cycles (saturating).
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (stateEntry) begin
      wait_cnt_d = {CW{1'b0}};
    end else if (inMemState && !memAck && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= {CW{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // An ack on the limit cycle wins, so the timeout is gated by !memAck.
  assign timeout = (ACK_TIMEOUT != 0) && inMemState && !memAck && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS core.
//   clkin, reset : clock, asynchronous active-low reset
//   bus (master) : opCode/memAck in; memory handshake, PC/IR/regfile/ALU
//                  mux and enable controls, trap status, debug state and
//                  retired-instruction count out.
// Controls are decoded from the state register alone, except irWrite and
// pcWrite in FETCH which follow memAck, so a reset drops them immediately.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic clkin,
  input  logic reset,
  mc_if.master bus
);

  state_t           state_q, state_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic             timeout_s;
  logic             in_mem_s;
  logic             entry_s;

  assign in_mem_s = is_mem_state(state_q);
  assign entry_s  = is_mem_state(state_d) && (state_d != state_q);

  mc_memwait #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_memwait (
    .clkin      (clkin),
    .reset      (reset),
    .inMemState (in_mem_s),
    .memAck     (bus.memAck),
    .stateEntry (entry_s),
    .timeout    (timeout_s)
  );

  // Next state, trap cause and retire count.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    inst_count_d = inst_count_q;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.memAck) begin
          state_d      = ST_DECODE;
          inst_count_d = inst_count_q + CNT_W'(1);
        end else if (timeout_s) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (bus.opCode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default: begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: begin
        if (bus.opCode == OP_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_MEMRD;
        end
      end
      ST_MEMRD, ST_MEMWR: begin
        if (bus.memAck) begin
          state_d = (state_q == ST_MEMRD) ? ST_MEMWB : ST_FETCH;
        end else if (timeout_s) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXEC:   state_d = ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      // Unreachable encodings restart the instruction sequence cleanly.
      default:   state_d = ST_START;
    endcase
  end

  // State, trap cause and retire count registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_START;
      trap_cause_q <= CAUSE_NONE;
      inst_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      inst_count_q <= inst_count_d;
    end
  end

  // Control decode from the current state.
  always_comb begin
    bus.memReq      = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.iorD        = 1'b0;
    bus.irWrite     = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSource    = PCSRC_ALU;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = SRCB_B;
    bus.aluop       = ALUOP_ADD;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regWrite    = 1'b0;
    bus.trap        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.memReq  = 1'b1;
        bus.memRead = 1'b1;
        bus.aluSrcB = SRCB_FOUR;
        bus.irWrite = bus.memAck;
        bus.pcWrite = bus.memAck;
      end
      ST_DECODE: bus.aluSrcB = SRCB_IMMSH2;
      ST_MEMADR, ST_ADDIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        bus.memReq  = 1'b1;
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      ST_MEMWR: begin
        bus.memReq   = 1'b1;
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
      end
      ST_EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluop   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 1'b1;
      end
      ST_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluop       = ALUOP_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = PCSRC_JUMP;
      end
      ST_ADDIWB: bus.regWrite = 1'b1;
      ST_TRAP:   bus.trap     = 1'b1;
      default:   bus.trap     = 1'b0;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.trapCause = trap_cause_q;
  assign bus.instCount = inst_count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, scoreboard-checked bench for mc_ctrl.
// Each stimulus cycle drives reset/opCode/memAck just after the rising edge
// and queues the hand-derived expected state, controls, count and cause;
// a monitor on the falling edge pops and compares.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mc_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.ACK_TIMEOUT(16), .CNT_W(32)) dut (
    .clkin (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [31:0] cnt;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;

  // Expected control word:
  // {memReq,memRead,memWrite,iorD,irWrite,pcWrite,pcWriteCond,pcSource,
  //  aluSrcA,aluSrcB,aluop,regDst,memToReg,regWrite,trap}
  function automatic logic [17:0] ctrl_of(input logic [3:0] st, input logic ack);
    logic req, rd, wr, iord, irw, pcw, pcwc, srca, rdst, m2r, rw, tr;
    logic [1:0] pcs, srcb, aop;
    {req, rd, wr, iord, irw, pcw, pcwc, srca, rdst, m2r, rw, tr} = 12'b0;
    pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
    case (st)
      4'd1:  begin req = 1'b1; rd = 1'b1; srcb = 2'b01; irw = ack; pcw = ack; end
      4'd2:  srcb = 2'b11;
      4'd3:  begin srca = 1'b1; srcb = 2'b10; end
      4'd4:  begin req = 1'b1; rd = 1'b1; iord = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin req = 1'b1; wr = 1'b1; iord = 1'b1; end
      4'd7:  begin srca = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rdst = 1'b1; end
      4'd9:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd10: begin pcw = 1'b1; pcs = 2'b10; end
      4'd11: begin srca = 1'b1; srcb = 2'b10; end
      4'd12: rw = 1'b1;
      4'd13: tr = 1'b1;
      default: tr = 1'b0;
    endcase
    return {req, rd, wr, iord, irw, pcw, pcwc, pcs, srca, srcb, aop, rdst, m2r, rw, tr};
  endfunction

  // One stimulus cycle plus its expected response.
  task automatic cyc(input logic r, input logic [5:0] op, input logic ack,
                     input logic [3:0] st, input logic [31:0] cnt, input logic [1:0] cause);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = r;
    bus.opCode = op;
    bus.memAck = ack;
    vec_id     = vec_id + 1;
    e.id    = 16'(vec_id);
    e.st    = st;
    e.ctrl  = ctrl_of(st, ack);
    e.cnt   = cnt;
    e.cause = cause;
    sb.push_back(e);
  endtask

  task automatic w(input logic [5:0] op, input logic ack, input logic [3:0] st,
                   input logic [31:0] cnt, input logic [1:0] cause);
    cyc(1'b1, op, ack, st, cnt, cause);
  endtask

  // Monitor: compare the DUT against the oldest expectation each falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [17:0] act;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {bus.memReq, bus.memRead, bus.memWrite, bus.iorD, bus.irWrite,
             bus.pcWrite, bus.pcWriteCond, bus.pcSource, bus.aluSrcA,
             bus.aluSrcB, bus.aluop, bus.regDst, bus.memToReg, bus.regWrite,
             bus.trap};
      n_vec = n_vec + 1;
      if (bus.state !== e.st) begin
        n_err = n_err + 1;
        $display("FAIL state v%0d: got %0d expected %0d", e.id, bus.state, e.st);
      end
      n_vec = n_vec + 1;
      if (act !== e.ctrl) begin
        n_err = n_err + 1;
        $display("FAIL ctrl v%0d (state %0d): got %b expected %b", e.id, e.st, act, e.ctrl);
      end
      n_vec = n_vec + 1;
      if (bus.instCount !== e.cnt) begin
        n_err = n_err + 1;
        $display("FAIL instCount v%0d: got %0d expected %0d", e.id, bus.instCount, e.cnt);
      end
      n_vec = n_vec + 1;
      if (bus.trapCause !== e.cause) begin
        n_err = n_err + 1;
        $display("FAIL trapCause v%0d: got %b expected %b", e.id, bus.trapCause, e.cause);
      end
    end
  end

  initial begin
    bus.opCode = 6'b000000;
    bus.memAck = 1'b0;

    // Reset held, then R-type with memAck tied high.
    cyc(1'b0, OP_RTYPE, 1'b0, 4'd0, 32'd0, 2'b00);
    cyc(1'b0, OP_RTYPE, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd0, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd1, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd2, 32'd1, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd7, 32'd1, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd8, 32'd1, 2'b00);

    // lw with three wait cycles in FETCH and in MEMRD.
    repeat (3) w(OP_LW, 1'b0, 4'd1, 32'd1, 2'b00);
    w(OP_LW, 1'b1, 4'd1, 32'd1, 2'b00);
    w(OP_LW, 1'b1, 4'd2, 32'd2, 2'b00);
    w(OP_LW, 1'b1, 4'd3, 32'd2, 2'b00);
    repeat (3) w(OP_LW, 1'b0, 4'd4, 32'd2, 2'b00);
    w(OP_LW, 1'b1, 4'd4, 32'd2, 2'b00);
    w(OP_LW, 1'b1, 4'd5, 32'd2, 2'b00);

    // beq, j, addi, sw.
    w(OP_BEQ, 1'b1, 4'd1, 32'd2, 2'b00);
    w(OP_BEQ, 1'b0, 4'd2, 32'd3, 2'b00);
    w(OP_BEQ, 1'b0, 4'd9, 32'd3, 2'b00);
    w(OP_J, 1'b1, 4'd1, 32'd3, 2'b00);
    w(OP_J, 1'b1, 4'd2, 32'd4, 2'b00);
    w(OP_J, 1'b1, 4'd10, 32'd4, 2'b00);
    w(OP_ADDI, 1'b1, 4'd1, 32'd4, 2'b00);
    w(OP_ADDI, 1'b1, 4'd2, 32'd5, 2'b00);
    w(OP_ADDI, 1'b1, 4'd11, 32'd5, 2'b00);
    w(OP_ADDI, 1'b1, 4'd12, 32'd5, 2'b00);
    w(OP_SW, 1'b1, 4'd1, 32'd5, 2'b00);
    w(OP_SW, 1'b1, 4'd2, 32'd6, 2'b00);
    w(OP_SW, 1'b1, 4'd3, 32'd6, 2'b00);
    w(OP_SW, 1'b0, 4'd6, 32'd6, 2'b00);
    w(OP_SW, 1'b1, 4'd6, 32'd6, 2'b00);

    // Illegal opcode: TRAP held for 20 cycles, acks ignored, count frozen.
    w(6'b111111, 1'b1, 4'd1, 32'd6, 2'b00);
    w(6'b111111, 1'b1, 4'd2, 32'd7, 2'b00);
    repeat (20) w(OP_RTYPE, 1'b1, 4'd13, 32'd7, 2'b01);

    // Reset clears the trap; ack on the 16th FETCH cycle still wins.
    cyc(1'b0, OP_RTYPE, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b0, 4'd0, 32'd0, 2'b00);
    repeat (15) w(OP_RTYPE, 1'b0, 4'd1, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b1, 4'd1, 32'd0, 2'b00);
    w(OP_RTYPE, 1'b0, 4'd2, 32'd1, 2'b00);
    w(OP_RTYPE, 1'b0, 4'd7, 32'd1, 2'b00);
    w(OP_RTYPE, 1'b0, 4'd8, 32'd1, 2'b00);

    // No ack for 16 FETCH cycles: memory timeout trap.
    repeat (16) w(OP_RTYPE, 1'b0, 4'd1, 32'd1, 2'b00);
    repeat (3) w(OP_RTYPE, 1'b1, 4'd13, 32'd1, 2'b10);

    // Reset in the second wait cycle of MEMWR.
    cyc(1'b0, OP_SW, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_SW, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_SW, 1'b1, 4'd1, 32'd0, 2'b00);
    w(OP_SW, 1'b0, 4'd2, 32'd1, 2'b00);
    w(OP_SW, 1'b0, 4'd3, 32'd1, 2'b00);
    w(OP_SW, 1'b0, 4'd6, 32'd1, 2'b00);
    cyc(1'b0, OP_SW, 1'b0, 4'd0, 32'd0, 2'b00);
    cyc(1'b0, OP_SW, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_SW, 1'b0, 4'd0, 32'd0, 2'b00);
    w(OP_SW, 1'b0, 4'd1, 32'd0, 2'b00);

    // Every queued expectation must have been consumed by the monitor.
    repeat (2) @(negedge clk);
    #1;
    n_vec = n_vec + 1;
    if (sb.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
